crtc_sync_meter: RTL and testbench

Passive consumer of the 6845-style CRTC video outputs (HSYNC, VSYNC, DE). It measures the horizontal and vertical timing actually produced, in character clocks and scanlines, and detects interlace. It reports lock once two consecutive frames agree. It sits beside the CRTC and feeds the scandoubler/OSD mode logic and the debug register readback.

---
 rtl/crtc_sync_meter.sv | 213 +++++++++++++++++++++
 tb/tb_crtc_sync_meter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/crtc_sync_meter.sv
// Purpose: passive meter of 6845-style CRTC HSYNC/VSYNC/DE timing, with interlace and lock detection.
// Latency: measured outputs and LOCKED update on the CLKEN edge that samples the VSYNC rising edge.
// Backpressure: none; the block only observes, and nothing happens on cycles where CLKEN is low.
module crtc_sync_meter #(
    parameter int HCNT_W = 9,
    parameter int VCNT_W = 10
) (
    input  logic              CLOCK,
    input  logic              nRESET,
    input  logic              CLKEN,
    input  logic              HSYNC,
    input  logic              VSYNC,
    input  logic              DE,
    output logic [HCNT_W-1:0] H_TOTAL,
    output logic [HCNT_W-1:0] H_SYNC_W,
    output logic [HCNT_W-1:0] H_DISP,
    output logic [VCNT_W-1:0] V_TOTAL,
    output logic [VCNT_W-1:0] V_SYNC_W,
    output logic [VCNT_W-1:0] V_DISP,
    output logic              INTERLACED,
    output logic              LOCKED,
    output logic              NO_SYNC
);
    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_MEASURE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam logic [HCNT_W-1:0] HMAX = {HCNT_W{1'b1}};
    localparam logic [VCNT_W-1:0] VMAX = {VCNT_W{1'b1}};
    localparam logic [HCNT_W-1:0] H1   = {{(HCNT_W-1){1'b0}}, 1'b1};
    localparam logic [VCNT_W-1:0] V1   = {{(VCNT_W-1){1'b0}}, 1'b1};

    logic              hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d, hs_acc_q, hs_acc_d, de_acc_q, de_acc_d;
    logic [HCNT_W-1:0] line_per_q, line_per_d, line_sw_q, line_sw_d, hdisp_max_q, hdisp_max_d;
    logic [HCNT_W-1:0] vs_phase_q, vs_phase_d;
    logic [VCNT_W-1:0] lcnt_q, lcnt_d, vs_lines_q, vs_lines_d, vsw_meas_q, vsw_meas_d;
    logic [VCNT_W-1:0] disp_lines_q, disp_lines_d;
    logic [HCNT_W-1:0] h_total_q, h_total_d, h_sync_w_q, h_sync_w_d, h_disp_q, h_disp_d;
    logic [VCNT_W-1:0] v_total_q, v_total_d, v_sync_w_q, v_sync_w_d, v_disp_q, v_disp_d;
    logic              interlaced_q, interlaced_d, no_sync_q, no_sync_d;
    logic [1:0]        state_q, state_d;

    logic              hs_rise, vs_rise, vs_fall, hsat, lsat, ilace, match;
    logic [HCNT_W-1:0] ph_diff;
    logic [VCNT_W-1:0] vt_diff;

    // Edge detection against the previous CLKEN sample.
    always_comb begin
        hs_rise = CLKEN & HSYNC & ~hs_prev_q;
        vs_rise = CLKEN & VSYNC & ~vs_prev_q;
        vs_fall = CLKEN & ~VSYNC & vs_prev_q;
    end

    // Line/frame accumulation, frame capture, interlace test and lock state machine.
    always_comb begin
        hs_prev_d    = hs_prev_q;
        vs_prev_d    = vs_prev_q;
        hcnt_d       = hcnt_q;
        hs_acc_d     = hs_acc_q;
        de_acc_d     = de_acc_q;
        line_per_d   = line_per_q;
        line_sw_d    = line_sw_q;
        hdisp_max_d  = hdisp_max_q;
        vs_phase_d   = vs_phase_q;
        lcnt_d       = lcnt_q;
        vs_lines_d   = vs_lines_q;
        vsw_meas_d   = vsw_meas_q;
        disp_lines_d = disp_lines_q;
        h_total_d    = h_total_q;
        h_sync_w_d   = h_sync_w_q;
        h_disp_d     = h_disp_q;
        v_total_d    = v_total_q;
        v_sync_w_d   = v_sync_w_q;
        v_disp_d     = v_disp_q;
        interlaced_d = interlaced_q;
        no_sync_d    = no_sync_q;
        state_d      = state_q;
        ph_diff      = '0;
        vt_diff      = '0;
        ilace        = 1'b0;
        match        = 1'b0;
        hsat         = 1'b0;
        lsat         = 1'b0;

        if (CLKEN) begin
            hs_prev_d = HSYNC;
            vs_prev_d = VSYNC;

            if (hs_rise) begin
                // Close the line; the current sample opens the next one.
                line_per_d  = (hcnt_q == HMAX) ? HMAX : hcnt_q + H1;
                line_sw_d   = hs_acc_q;
                hdisp_max_d = (de_acc_q > hdisp_max_q) ? de_acc_q : hdisp_max_q;
                hcnt_d      = '0;
                hs_acc_d    = H1;
                de_acc_d    = DE ? H1 : '0;
                lcnt_d      = (lcnt_q == VMAX) ? VMAX : lcnt_q + V1;
                if (VSYNC && vs_lines_q != VMAX) vs_lines_d = vs_lines_q + V1;
                if (de_acc_q != '0 && disp_lines_q != VMAX) disp_lines_d = disp_lines_q + V1;
            end else begin
                hsat   = (hcnt_q == HMAX);
                hcnt_d = hsat ? HMAX : hcnt_q + H1;
                if (HSYNC && hs_acc_q != HMAX) hs_acc_d = hs_acc_q + H1;
                if (DE && de_acc_q != HMAX)    de_acc_d = de_acc_q + H1;
            end

            // The vsync width of a frame is only known once VSYNC drops.
            if (vs_fall) vsw_meas_d = vs_lines_q;

            if (vs_rise) begin
                ph_diff = (hcnt_d >= vs_phase_q) ? hcnt_d - vs_phase_q : vs_phase_q - hcnt_d;
                vt_diff = (lcnt_d >= v_total_q) ? lcnt_d - v_total_q : v_total_q - lcnt_d;
                ilace   = (ph_diff >= (line_per_d >> 2)) && (vt_diff <= V1);
                match   = (line_per_d == h_total_q) && (line_sw_d == h_sync_w_q) &&
                          (hdisp_max_d == h_disp_q) && (vsw_meas_q == v_sync_w_q) &&
                          (disp_lines_d == v_disp_q) &&
                          ((lcnt_d == v_total_q) || ilace);

                h_total_d    = line_per_d;
                h_sync_w_d   = line_sw_d;
                h_disp_d     = hdisp_max_d;
                v_total_d    = lcnt_d;
                v_sync_w_d   = vsw_meas_q;
                v_disp_d     = disp_lines_d;
                interlaced_d = ilace;
                vs_phase_d   = hcnt_d;
                no_sync_d    = 1'b0;

                // A coincident hsync already counts as the first vsync line.
                vs_lines_d   = hs_rise ? V1 : '0;
                lcnt_d       = '0;
                disp_lines_d = '0;
                hdisp_max_d  = '0;

                case (state_q)
                    ST_UNLOCKED: state_d = ST_MEASURE;
                    ST_MEASURE:  state_d = match ? ST_LOCKED : ST_MEASURE;
                    ST_LOCKED:   state_d = match ? ST_LOCKED : ST_MEASURE;
                    default:     state_d = ST_UNLOCKED;
                endcase
            end

            // Missing sync overrides everything else.
            lsat = hs_rise && !vs_rise && (lcnt_q == VMAX);
            if (hsat || lsat) begin
                state_d   = ST_UNLOCKED;
                no_sync_d = 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            hcnt_q       <= '0;
            hs_acc_q     <= '0;
            de_acc_q     <= '0;
            line_per_q   <= '0;
            line_sw_q    <= '0;
            hdisp_max_q  <= '0;
            vs_phase_q   <= '0;
            lcnt_q       <= '0;
            vs_lines_q   <= '0;
            vsw_meas_q   <= '0;
            disp_lines_q <= '0;
            h_total_q    <= '0;
            h_sync_w_q   <= '0;
            h_disp_q     <= '0;
            v_total_q    <= '0;
            v_sync_w_q   <= '0;
            v_disp_q     <= '0;
            interlaced_q <= 1'b0;
            no_sync_q    <= 1'b0;
            state_q      <= ST_UNLOCKED;
        end else begin
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            hcnt_q       <= hcnt_d;
            hs_acc_q     <= hs_acc_d;
            de_acc_q     <= de_acc_d;
            line_per_q   <= line_per_d;
            line_sw_q    <= line_sw_d;
            hdisp_max_q  <= hdisp_max_d;
            vs_phase_q   <= vs_phase_d;
            lcnt_q       <= lcnt_d;
            vs_lines_q   <= vs_lines_d;
            vsw_meas_q   <= vsw_meas_d;
            disp_lines_q <= disp_lines_d;
            h_total_q    <= h_total_d;
            h_sync_w_q   <= h_sync_w_d;
            h_disp_q     <= h_disp_d;
            v_total_q    <= v_total_d;
            v_sync_w_q   <= v_sync_w_d;
            v_disp_q     <= v_disp_d;
            interlaced_q <= interlaced_d;
            no_sync_q    <= no_sync_d;
            state_q      <= state_d;
        end
    end

    assign H_TOTAL    = h_total_q;
    assign H_SYNC_W   = h_sync_w_q;
    assign H_DISP     = h_disp_q;
    assign V_TOTAL    = v_total_q;
    assign V_SYNC_W   = v_sync_w_q;
    assign V_DISP     = v_disp_q;
    assign INTERLACED = interlaced_q;
    assign NO_SYNC    = no_sync_q;
    assign LOCKED     = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_crtc_sync_meter.sv
// Directed bench for crtc_sync_meter: a behavioural CRTC drives 64-char lines (hsync at 49, width 8)
// with a shortened vertical geometry (40-line fields, 32 display lines, 2-line vsync at line 36)
// so every scenario fits in a short run; interlace adds a 41-line field with vsync half a line late.
module tb_crtc_sync_meter;
    localparam int HCHARS     = 64;
    localparam int VS_LINE    = 36;
    localparam int DISP_LINES = 32;

    logic       CLOCK, nRESET, CLKEN, HSYNC, VSYNC, DE;
    logic [8:0] H_TOTAL, H_SYNC_W, H_DISP;
    logic [9:0] V_TOTAL, V_SYNC_W, V_DISP;
    logic       INTERLACED, LOCKED, NO_SYNC;

    int vectors    = 0;
    int miscompares = 0;
    int n_ticks    = 0;

    crtc_sync_meter #(.HCNT_W(9), .VCNT_W(10)) dut (
        .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE),
        .H_TOTAL(H_TOTAL), .H_SYNC_W(H_SYNC_W), .H_DISP(H_DISP),
        .V_TOTAL(V_TOTAL), .V_SYNC_W(V_SYNC_W), .V_DISP(V_DISP),
        .INTERLACED(INTERLACED), .LOCKED(LOCKED), .NO_SYNC(NO_SYNC)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One character clock; every 16th character is followed by an idle (CLKEN=0) cycle.
    task automatic tick();
        CLKEN = 1'b1;
        @(posedge CLOCK);
        #1;
        n_ticks++;
        if (n_ticks % 16 == 0) begin
            CLKEN = 1'b0;
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic gen_field(input int nlines, input int vs_off, input int hs_pos,
                             input int hsw, input int r1, input int stop_line);
        int vsp;
        vsp = VS_LINE * HCHARS + vs_off;
        for (int lin = 0; lin < nlines && lin < stop_line; lin++) begin
            for (int ch = 0; ch < HCHARS; ch++) begin
                int pos;
                pos   = lin * HCHARS + ch;
                HSYNC = (ch >= hs_pos) && (ch < hs_pos + hsw);
                VSYNC = (pos >= vsp) && (pos < vsp + 2 * HCHARS);
                DE    = (lin < DISP_LINES) && (ch < r1);
                tick();
            end
        end
    endtask

    task automatic chk_frame(input string tag, input int ht, input int hd, input int vt);
        chk({tag, ".H_TOTAL"},  H_TOTAL,  ht);
        chk({tag, ".H_SYNC_W"}, H_SYNC_W, 8);
        chk({tag, ".H_DISP"},   H_DISP,   hd);
        chk({tag, ".V_TOTAL"},  V_TOTAL,  vt);
        chk({tag, ".V_SYNC_W"}, V_SYNC_W, 2);
        chk({tag, ".V_DISP"},   V_DISP,   DISP_LINES);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".H_TOTAL"},  H_TOTAL,  0);
        chk({tag, ".H_SYNC_W"}, H_SYNC_W, 0);
        chk({tag, ".H_DISP"},   H_DISP,   0);
        chk({tag, ".V_TOTAL"},  V_TOTAL,  0);
        chk({tag, ".V_SYNC_W"}, V_SYNC_W, 0);
        chk({tag, ".V_DISP"},   V_DISP,   0);
        chk({tag, ".INTERLACED"}, INTERLACED, 0);
        chk({tag, ".LOCKED"},   LOCKED,   0);
        chk({tag, ".NO_SYNC"},  NO_SYNC,  0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET = 1'b0; CLKEN = 1'b0; HSYNC = 1'b0; VSYNC = 1'b0; DE = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        chk_zero("reset");
        nRESET = 1'b1;

        // Progressive timing: partial frame, first full frame, then lock.
        gen_field(40, 0, 49, 8, 40, 999);
        chk("f1.LOCKED", LOCKED, 0);
        gen_field(40, 0, 49, 8, 40, 999);
        chk("f2.LOCKED", LOCKED, 0);
        chk("f2.V_TOTAL", V_TOTAL, 40);
        gen_field(40, 0, 49, 8, 40, 999);
        chk_frame("f3", 64, 40, 40);
        chk("f3.LOCKED", LOCKED, 1);
        chk("f3.INTERLACED", INTERLACED, 0);
        chk("f3.NO_SYNC", NO_SYNC, 0);

        // Display width change: one frame out of lock, then relock.
        gen_field(40, 0, 49, 8, 32, 999);
        chk("r1.H_DISP", H_DISP, 32);
        chk("r1.LOCKED", LOCKED, 0);
        gen_field(40, 0, 49, 8, 32, 999);
        chk("r1b.H_DISP", H_DISP, 32);
        chk("r1b.LOCKED", LOCKED, 1);

        // Hsync moved to char 0 so it coincides with the vsync rise.
        gen_field(40, 0, 0, 8, 40, 999);
        chk("sim1.V_TOTAL", V_TOTAL, 41);
        chk("sim1.LOCKED", LOCKED, 0);
        gen_field(40, 0, 0, 8, 40, 999);
        chk_frame("sim2", 64, 40, 40);
        chk("sim2.LOCKED", LOCKED, 0);
        gen_field(40, 0, 0, 8, 40, 999);
        chk("sim3.V_TOTAL", V_TOTAL, 40);
        chk("sim3.LOCKED", LOCKED, 1);

        // Reset in the middle of a frame with the character clock stalled.
        gen_field(40, 0, 0, 8, 40, 20);
        CLKEN  = 1'b0;
        nRESET = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) @(posedge CLOCK);
        #1;
        nRESET = 1'b1;
        gen_field(40, 0, 49, 8, 40, 999);
        gen_field(40, 0, 49, 8, 40, 999);
        chk("relock2.LOCKED", LOCKED, 0);
        gen_field(40, 0, 49, 8, 40, 999);
        chk("relock3.LOCKED", LOCKED, 1);
        chk_frame("relock3", 64, 40, 40);

        // Interlace: vsync half a line late on the long field.
        gen_field(41, 32, 49, 8, 40, 999);
        chk("ilB.INTERLACED", INTERLACED, 1);
        chk("ilB.LOCKED", LOCKED, 1);
        chk("ilB.V_TOTAL", V_TOTAL, 40);
        gen_field(40, 0, 49, 8, 40, 999);
        chk("ilA.INTERLACED", INTERLACED, 1);
        chk("ilA.LOCKED", LOCKED, 1);
        chk("ilA.V_TOTAL", V_TOTAL, 41);

        // Hsync stops: one final rise, then timeout on the 512th character after it.
        HSYNC = 1'b1; VSYNC = 1'b0; DE = 1'b0;
        tick();
        HSYNC = 1'b0;
        repeat (511) tick();
        chk("nosync511.NO_SYNC", NO_SYNC, 0);
        chk("nosync511.LOCKED", LOCKED, 1);
        tick();
        chk("nosync512.NO_SYNC", NO_SYNC, 1);
        chk("nosync512.LOCKED", LOCKED, 0);
        HSYNC = 1'b1; VSYNC = 1'b1;
        tick();
        chk("resync.NO_SYNC", NO_SYNC, 0);
        chk("resync.LOCKED", LOCKED, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
